pulse_stretch_mc: RTL and testbench

PULSE_STRETCH_MC -- requirements
Module: pulse_stretch_mc

---
 rtl/pulse_stretch_mc.sv | 103 ++++++++++
 tb/tb_pulse_stretch_mc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: each trigger event holds its channel's out high for len cycles.
// Latency: out rises the cycle after the event is sampled; done pulses the cycle after out falls.
// No backpressure: every channel runs freely every cycle; len is shared and sampled only at accepted events.
module pulse_stretch_mc #(
  parameter int CH     = 4,
  parameter int CW     = 8,
  parameter int EDGE   = 0,
  parameter int RETRIG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] trig,
  input  logic [CW-1:0] len,
  output logic [CH-1:0] out,
  output logic [CH-1:0] done,
  output logic          busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // Reload-while-active is a build-time choice; folding it into a bit keeps the channel logic flat.
  localparam bit RELOAD = (RETRIG != 0);

  logic          w_len_nz;
  logic [CH-1:0] w_evt;

  // A zero length never starts or reloads a stretch, so one shared compare serves every channel.
  assign w_len_nz = |len;

  generate
    if (EDGE != 0) begin : g_edge
      logic [CH-1:0] r_trig_d;

      // Previous-cycle trig; cleared in reset so a trig already high at release reads as a rising edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_trig_d <= '0;
        end else begin
          r_trig_d <= trig;
        end
      end

      assign w_evt = trig & ~r_trig_d;
    end else begin : g_level
      assign w_evt = trig;
    end
  endgenerate

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      state_t        r_state;
      logic [CW-1:0] r_cnt;
      logic          r_done;
      logic          w_reload;

      // Reload only counts as an event when it would load a usable length.
      assign w_reload = RELOAD & w_evt[i] & w_len_nz;

      // Per-channel IDLE/ACTIVE machine; reload beats expiry, and cnt leaves ACTIVE at 1 so it never wraps.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_done  <= 1'b0;
        end else begin
          r_done <= 1'b0;
          case (r_state)
            S_IDLE: begin
              if (w_evt[i] && w_len_nz) begin
                r_state <= S_ACTIVE;
                r_cnt   <= len;
              end
            end
            S_ACTIVE: begin
              if (w_reload) begin
                r_cnt <= len;
              end else if (r_cnt == CW'(1)) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt - CW'(1);
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end

      assign out[i]  = (r_state == S_ACTIVE);
      assign done[i] = r_done;
    end
  endgenerate

  assign busy = |out;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Directed bench for pulse_stretch_mc: level/retrigger, edge/no-retrigger and a 2-bit-width build.
// Each step applies one cycle of trig/len, then samples out/done/busy 1ns after the clock edge.
// Expected waveforms are written as bit strings in time order, leftmost bit = first sampled cycle.
module tb_pulse_stretch_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] trig_a, trig_b;
  logic       trig_c;
  logic [7:0] len;
  logic [1:0] len_c;
  logic [3:0] out_a, done_a, out_b, done_b;
  logic       out_c, done_c;
  logic       busy_a, busy_b, busy_c;

  logic [15:0] tv [4];
  logic [15:0] eo [4];
  logic [15:0] ed [4];
  logic [7:0]  ln [16];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pulse_stretch_mc #(.CH(4), .CW(8), .EDGE(0), .RETRIG(1)) u_lvl (
    .clk(clk), .rst(rst), .trig(trig_a), .len(len),
    .out(out_a), .done(done_a), .busy(busy_a)
  );

  pulse_stretch_mc #(.CH(4), .CW(8), .EDGE(1), .RETRIG(0)) u_edg (
    .clk(clk), .rst(rst), .trig(trig_b), .len(len),
    .out(out_b), .done(done_b), .busy(busy_b)
  );

  pulse_stretch_mc #(.CH(1), .CW(2), .EDGE(0), .RETRIG(1)) u_w2 (
    .clk(clk), .rst(rst), .trig(trig_c), .len(len_c),
    .out(out_c), .done(done_c), .busy(busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input logic [7:0] l);
    for (int c = 0; c < 4; c++) begin
      tv[c] = '0;
      eo[c] = '0;
      ed[c] = '0;
    end
    for (int p = 0; p < 16; p++) ln[p] = l;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_a"},  {28'b0, out_a},  32'd0);
    chk({tag, " done_a"}, {28'b0, done_a}, 32'd0);
    chk({tag, " busy_a"}, {31'b0, busy_a}, 32'd0);
    chk({tag, " out_b"},  {28'b0, out_b},  32'd0);
    chk({tag, " done_b"}, {28'b0, done_b}, 32'd0);
    chk({tag, " busy_c"}, {31'b0, busy_c}, 32'd0);
  endtask

  // sel: 0 = level/retrigger DUT, 1 = edge/no-retrigger DUT, 2 = CW=2 single-channel DUT
  task automatic run(input string tag, input int sel, input int n);
    logic [3:0] tvec, xo, xd, go, gd;
    logic       gb;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 4; c++) begin
        tvec[c] = tv[c][n-1-p];
        xo[c]   = eo[c][n-1-p];
        xd[c]   = ed[c][n-1-p];
      end
      len   = ln[p];
      len_c = ln[p][1:0];
      case (sel)
        0:       trig_a = tvec;
        1:       trig_b = tvec;
        default: trig_c = tvec[0];
      endcase
      tick();
      case (sel)
        0:       begin go = out_a; gd = done_a; gb = busy_a; end
        1:       begin go = out_b; gd = done_b; gb = busy_b; end
        default: begin go = {3'b0, out_c}; gd = {3'b0, done_c}; gb = busy_c; end
      endcase
      chk($sformatf("%s out p%0d", tag, p),  {28'b0, go}, {28'b0, xo});
      chk($sformatf("%s done p%0d", tag, p), {28'b0, gd}, {28'b0, xd});
      chk($sformatf("%s busy p%0d", tag, p), {31'b0, gb}, {31'b0, |xo});
    end
    trig_a = '0;
    trig_b = '0;
    trig_c = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    trig_a = '0;
    trig_b = '0;
    trig_c = 1'b0;
    len    = '0;
    len_c  = '0;
    #2;
    chk_all_zero("reset_async");
    tick();
    tick();
    chk_all_zero("reset_held");
    rst = 1'b0;

    // single trigger, len=4: four cycles of out, then one done
    clr(8'd4);
    tv[0] = 16'b1000000; eo[0] = 16'b1111000; ed[0] = 16'b0000100;
    run("len4", 0, 7);

    // new trigger in the done cycle starts a fresh stretch
    clr(8'd2);
    tv[0] = 16'b10010000; eo[0] = 16'b11011000; ed[0] = 16'b00100100;
    run("trig_in_done", 0, 8);

    // trig held 5 cycles, len=3: out high 7 cycles, single done
    clr(8'd3);
    tv[1] = 16'b1111100000; eo[1] = 16'b1111111000; ed[1] = 16'b0000000100;
    run("held_len3", 0, 10);

    // retrigger on the expiry edge wins: no done, count reloaded
    clr(8'd2);
    tv[2] = 16'b1010000; eo[2] = 16'b1111000; ed[2] = 16'b0000100;
    run("reload_at_expiry", 0, 7);

    // len=0 discarded, then len=1 gives one cycle out plus done
    clr(8'd0);
    tv[0] = 16'b1000;
    run("len0", 0, 4);
    clr(8'd1);
    tv[0] = 16'b1000; eo[0] = 16'b1000; ed[0] = 16'b0100;
    run("len1", 0, 4);

    // reset mid-stretch aborts at once, no done afterwards, then a full stretch
    clr(8'd6);
    tv[0] = 16'b100; eo[0] = 16'b111;
    run("pre_rst", 0, 3);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    chk_all_zero("rst_mid_held");
    rst = 1'b0;
    clr(8'd6);
    run("post_rst_quiet", 0, 4);
    clr(8'd6);
    tv[0] = 16'b10000000; eo[0] = 16'b11111100; ed[0] = 16'b00000010;
    run("full6", 0, 8);

    // edge, no retrigger: second rising edge ignored
    clr(8'd5);
    tv[2] = 16'b10100000; eo[2] = 16'b11111000; ed[2] = 16'b00000100;
    run("edge_norel", 1, 8);

    // edge: a held trig is a single event
    clr(8'd2);
    tv[3] = 16'b111100; eo[3] = 16'b110000; ed[3] = 16'b001000;
    run("edge_held", 1, 6);

    // edge, no retrigger: edge on the expiry edge ignored, no queuing
    clr(8'd2);
    tv[0] = 16'b101000; eo[0] = 16'b110000; ed[0] = 16'b001000;
    run("edge_expiry", 1, 6);

    // trig already high across reset release counts as a rising edge
    rst    = 1'b1;
    trig_b = 4'b0010;
    len    = 8'd3;
    tick();
    tick();
    rst = 1'b0;
    clr(8'd3);
    tv[1] = 16'b1111111; eo[1] = 16'b1110000; ed[1] = 16'b0001000;
    run("edge_after_rst", 1, 7);

    // four channels at different cycles, len 7/2/7/2, len changed between events
    clr(8'd1);
    ln[0] = 8'd7; ln[2] = 8'd2; ln[4] = 8'd7; ln[5] = 8'd2;
    tv[0] = 16'b1000000000000; eo[0] = 16'b1111111000000; ed[0] = 16'b0000000100000;
    tv[1] = 16'b0010000000000; eo[1] = 16'b0011000000000; ed[1] = 16'b0000100000000;
    tv[2] = 16'b0000100000000; eo[2] = 16'b0000111111100; ed[2] = 16'b0000000000010;
    tv[3] = 16'b0000010000000; eo[3] = 16'b0000011000000; ed[3] = 16'b0000000100000;
    run("multi", 0, 13);

    // CW=2, len at maximum 3: three cycles of out
    clr(8'd3);
    tv[0] = 16'b100000; eo[0] = 16'b111000; ed[0] = 16'b000100;
    run("cw2_max", 2, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
